ftdi_tx_packer: RTL

Frames a user word stream into length-prefixed, checksummed packets and drives the transmit side of `ftdi_245fifo` (`tx_valid`/`tx_ready`/`tx_data`). It sits directly upstream of `ftdi_245fifo` in the `tx_clk` domain. The host can then re-synchronise on packet boundaries and validate payloads.
- Each packet is buffered in full before emission, so the length word is known up front.
- A frame is emitted as: SYNC, LEN, payload, CHECKSUM.

---
 rtl/ftdi_pack_pkg.sv | 18 +
 rtl/pack_buf_ram.sv | 26 ++
 rtl/ftdi_tx_packer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ftdi_pack_pkg.sv
// Shared types and constants for the FTDI transmit packet framer.
package ftdi_pack_pkg;

  typedef enum logic [2:0] {
    StFill,
    StHdr,
    StLen,
    StPay,
    StSum
  } state_e;

  localparam logic [7:0] SyncByte = 8'hA5;

  function automatic int unsigned W(input int unsigned dexp);
    return 32'd8 << dexp;
  endfunction

endpackage

// File: rtl/pack_buf_ram.sv
// Payload buffer: simple dual-port RAM, one write port, registered read port.
module pack_buf_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [2**AddrW];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ftdi_tx_packer.sv
// Buffers one packet, then emits SYNC, LEN, payload[, CHECKSUM] towards ftdi_245fifo.
// Define FTDI_TX_PACKER_CHECKSUM_EN to append the CHECKSUM word.
module ftdi_tx_packer import ftdi_pack_pkg::*; #(
  parameter int unsigned          DEXP = 1,
  parameter int unsigned          AEXP = 8,
  parameter logic [W(DEXP)-1:0]   SYNC = {(1 << DEXP){SyncByte}}
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [W(DEXP)-1:0]  in_data_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W(DEXP)-1:0]  out_data_o,
  output logic                trunc_o
);

  localparam int unsigned DW    = W(DEXP);
  localparam int unsigned Depth = 2 ** AEXP;
  localparam int unsigned PtrW  = AEXP + 1;

  if (AEXP > DW) begin : g_aexp_chk
    $error("AEXP must not exceed the data width");
  end

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [DW-1:0]     len_word;
  logic [DW-1:0]     buf_rdata;
  logic              buf_we;
  logic              in_ready;
  logic              trunc;
  logic              out_fire;
  logic              at_max;
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
  logic [DW-1:0]     acc_q, acc_d;
`endif

  assign out_fire = out_valid_q & out_ready_i;
  assign at_max   = (wptr_q == PtrW'(Depth - 1));
  assign len_word = DW'(wptr_q - 1'b1);

  pack_buf_ram #(
    .Width (DW),
    .AddrW (AEXP)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (wptr_q[AEXP-1:0]),
    .wdata_i (in_data_i),
    .raddr_i (rptr_d[AEXP-1:0]),
    .rdata_o (buf_rdata)
  );

  // Reading at rptr_d keeps buf_rdata == buffer[rptr_q], so the next payload word is ready
  // the moment the current output word is taken.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    buf_we      = 1'b0;
    in_ready    = 1'b0;
    trunc       = 1'b0;
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
          acc_d  = acc_q + in_data_i;
`endif
          if (in_last_i || at_max) begin
            trunc       = ~in_last_i;
            state_d     = StHdr;
            out_valid_d = 1'b1;
            out_data_d  = SYNC;
            rptr_d      = '0;
          end
        end
      end
      StHdr: begin
        if (out_fire) begin
          out_data_d = len_word;
          state_d    = StLen;
        end
      end
      StLen: begin
        if (out_fire) begin
          out_data_d = buf_rdata;
          rptr_d     = rptr_q + 1'b1;
          state_d    = StPay;
        end
      end
      StPay: begin
        if (out_fire) begin
          if (rptr_q == wptr_q) begin
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
            out_data_d = -(acc_q + len_word);
            state_d    = StSum;
`else
            out_valid_d = 1'b0;
            out_data_d  = '0;
            wptr_d      = '0;
            rptr_d      = '0;
            state_d     = StFill;
`endif
          end else begin
            out_data_d = buf_rdata;
            rptr_d     = rptr_q + 1'b1;
          end
        end
      end
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
      StSum: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          wptr_d      = '0;
          rptr_d      = '0;
          acc_d       = '0;
          state_d     = StFill;
        end
      end
`endif
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StFill;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FTDI_TX_PACKER_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign in_ready_o  = in_ready;
  assign trunc_o     = trunc;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule
